// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the load/store port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-port priority.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no access in flight; a pending request issues at the next edge
// ST_BUSY | access in flight; cnt_q counts down to the response cycle (cnt_q==1)

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  // Loaded in the mem_en cycle so that cnt_q==1 lands MEM_LAT cycles later.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                own_data_q, own_data_d;
  logic                if_gnt_q, if_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;

  logic rsp_cycle;
  logic issue_slot;
  logic any_req;
  logic pick_data;

  assign rsp_cycle  = (state_q == ST_BUSY) && (cnt_q == 4'd1);
  assign issue_slot = (state_q == ST_IDLE) || rsp_cycle;
  assign any_req    = if_req || d_req;

`ifdef MEM_ARB_RR_EN
  logic last_data_q, last_data_d;
  // On a tie, the port that was not served last wins.
  assign pick_data = d_req && (!if_req || !last_data_q);
`else
  assign pick_data = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_data_d  = own_data_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
`ifdef MEM_ARB_RR_EN
    last_data_d = last_data_q;
`endif

    if ((state_q == ST_BUSY) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (rsp_cycle) begin
      state_d = ST_IDLE;
    end

    if (issue_slot && any_req) begin
      state_d    = ST_BUSY;
      cnt_d      = CNT_LOAD;
      own_data_d = pick_data;
      mem_en_d   = 1'b1;
`ifdef MEM_ARB_RR_EN
      last_data_d = pick_data;
`endif
      if (pick_data) begin
        d_gnt_d     = 1'b1;
        mem_we_d    = d_we;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_we ? d_wdata : '0;
        mem_be_d    = d_we ? d_be : '1;
      end else begin
        if_gnt_d    = 1'b1;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
        mem_be_d    = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      own_data_q  <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
`ifdef MEM_ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_data_q  <= own_data_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
`ifdef MEM_ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  // Read data is routed straight from memory and gated to zero outside the response cycle.
  assign if_rvalid = rsp_cycle && !own_data_q;
  assign d_rvalid  = rsp_cycle && own_data_q;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/responses, a negedge monitor checks them.
// Expected grant order follows MEM_ARB_RR_EN when it is defined.

module tb_mem_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: read data exists only in the LAT-th cycle after mem_en.
  logic [LAT:1] pv = '0;
  logic [31:0]  pa [1:LAT];
  always @(posedge clk) begin
    pv[1] <= mem_en && !mem_we;
    pa[1] <= mem_addr;
    for (int k = 2; k <= LAT; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
  end
  assign mem_rdata = pv[LAT] ? memfn(pa[LAT]) : 32'hBAD0_BAD0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit d; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int cyc;} gexp_t;
  typedef struct {bit d; bit we; logic [31:0] data; int cyc;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_gnt(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int g);
    gexp_t e;
    rexp_t r;
    e.d = d; e.we = we; e.addr = a; e.wdata = wd; e.be = (d && we) ? be : 4'hF; e.cyc = g;
    gq.push_back(e);
    r.d = d; r.we = we; r.data = memfn(a); r.cyc = g + LAT;
    rq.push_back(r);
  endtask

  logic prev_en = 1'b0;
  always @(negedge clk) begin
    gexp_t e;
    rexp_t r;
    if (mem_en) chk("mem_en_spacing", 64'(prev_en), 64'(0));
    prev_en = mem_en;
    if (if_gnt || d_gnt || mem_en) begin
      if (gq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant: if_gnt=%0b d_gnt=%0b mem_en=%0b, none required (cycle %0d)",
                 if_gnt, d_gnt, mem_en, cyc);
      end else begin
        e = gq.pop_front();
        chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
        chk("d_gnt", 64'(d_gnt), 64'(e.d));
        chk("if_gnt", 64'(if_gnt), 64'(!e.d));
        chk("mem_en", 64'(mem_en), 64'(1));
        chk("mem_we", 64'(mem_we), 64'(e.we));
        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        chk("mem_be", 64'(mem_be), 64'(e.be));
        if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
      end
    end
    if (if_rvalid || d_rvalid) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid: if_rvalid=%0b d_rvalid=%0b, none required (cycle %0d)",
                 if_rvalid, d_rvalid, cyc);
      end else begin
        r = rq.pop_front();
        chk("rvalid_cycle", 64'(cyc), 64'(r.cyc));
        chk("d_rvalid", 64'(d_rvalid), 64'(r.d));
        chk("if_rvalid", 64'(if_rvalid), 64'(!r.d));
        if (r.d) begin
          if (!r.we) chk("d_rdata", 64'(d_rdata), 64'(r.data));
          chk("if_rdata_gated", 64'(if_rdata), 64'(0));
        end else begin
          chk("if_rdata", 64'(if_rdata), 64'(r.data));
          chk("d_rdata_gated", 64'(d_rdata), 64'(0));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_if_gnt"}, 64'(if_gnt), 64'(0));
    chk({tag, "_if_rvalid"}, 64'(if_rvalid), 64'(0));
    chk({tag, "_if_rdata"}, 64'(if_rdata), 64'(0));
    chk({tag, "_d_gnt"}, 64'(d_gnt), 64'(0));
    chk({tag, "_d_rvalid"}, 64'(d_rvalid), 64'(0));
    chk({tag, "_d_rdata"}, 64'(d_rdata), 64'(0));
    chk({tag, "_mem_en"}, 64'(mem_en), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_mem_be"}, 64'(mem_be), 64'(0));
  endtask

  // One uncontended transaction from an idle arbiter.
  task automatic single(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be);
    push_gnt(d, we, a, wd, be, cyc + 1);
    if (d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    step();
    d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
    repeat (LAT + 1) step();
  endtask

  function automatic bit win_data(input int k, input bit both);
    if (!both) return 1'b1;
`ifdef MEM_ARB_RR_EN
    return (k % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // Requests held high across n grants; the winner's address advances the cycle after each grant.
  task automatic stream(input int n, input bit both);
    int base;
    int nd;
    int ni;
    int g;
    bit w;
    base = cyc;
    nd = 0;
    ni = 0;
    for (int k = 0; k < n; k++) begin
      w = win_data(k, both);
      if (w) begin
        push_gnt(1'b1, 1'b0, 32'h200 + 32'(4 * nd), 32'h0, 4'h0, base + 1 + k * (LAT + 1));
        nd++;
      end else begin
        push_gnt(1'b0, 1'b0, 32'h300 + 32'(4 * ni), 32'h0, 4'h0, base + 1 + k * (LAT + 1));
        ni++;
      end
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    if (both) begin
      if_req = 1'b1; if_addr = 32'h300;
    end
    for (int k = 0; k < n; k++) begin
      g = base + 1 + k * (LAT + 1);
      while (cyc < g) step();
      if (k == n - 1) begin
        d_req = 1'b0; if_req = 1'b0;
      end else begin
        step();
        if (win_data(k, both)) d_addr = d_addr + 32'd4;
        else if_addr = if_addr + 32'd4;
      end
    end
    repeat (LAT + 1) step();
  endtask

  initial begin
    int base;
    int t;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b1;
    step();
    step();

    // Fetch from 0x10.
    single(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);

    // Simultaneous data read 0x100 and fetch 0x0: data first, fetch LAT+1 cycles later.
    base = cyc;
    push_gnt(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, base + 1);
    push_gnt(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, base + LAT + 2);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h0;
    step();
    d_req = 1'b0;
    repeat (LAT + 1) step();
    if_req = 1'b0;
    repeat (LAT + 1) step();

    // Both ports held for four grants.
    stream(4, 1'b1);

    // Partial write.
    single(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'h3);

    // Reset one cycle after mem_en: the access is abandoned and never answered.
    base = cyc;
    t = 0;
    gq.push_back('{d: 1'b1, we: 1'b0, addr: 32'h40, wdata: 32'h0, be: 4'hF, cyc: base + 1});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    step();
    d_req = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    step();
    step();
    reset = 1'b1;
    repeat (LAT + 3) step();
    single(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);

    // Continuous data requests.
    stream(4, 1'b0);

    while ((gq.size() != 0 || rq.size() != 0) && t < 50) begin
      step();
      t++;
    end
    chk("grant_queue_drained", 64'(gq.size()), 64'(0));
    chk("resp_queue_drained", 64'(rq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
